// File: rtl/mips_wback_pkg.sv
// Shared definitions for the MIPS I register-file writer: load op codes,
// controller state encoding and the latched load request.
package mips_wback_pkg;

   localparam logic [2:0] MIPS_LB  = 3'b000;
   localparam logic [2:0] MIPS_LH  = 3'b001;
   localparam logic [2:0] MIPS_LWL = 3'b010;
   localparam logic [2:0] MIPS_LW  = 3'b011;
   localparam logic [2:0] MIPS_LBU = 3'b100;
   localparam logic [2:0] MIPS_LHU = 3'b101;
   localparam logic [2:0] MIPS_LWR = 3'b110;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_WAIT = 1'b1;

   localparam logic [3:0] WE_ALL = 4'b1111;

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] a;
      logic [4:0] rd;
   } ld_req_t;

endpackage

// File: rtl/mips_load_align.sv
// Combinational load formatter: selects, shifts and extends the aligned memory
// word and produces the matching register byte enables (little-endian).
module mips_load_align
   import mips_wback_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  a,
   input  logic [31:0] mem_D,
   output logic [3:0]  we,
   output logic [31:0] D
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;
   logic [1:0]  a_inv;
   logic [4:0]  lsh;
   logic [4:0]  rsh;

   assign byte_s = mem_D[{a, 3'b000} +: 8];
   assign half_s = a[1] ? mem_D[31:16] : mem_D[15:0];
   assign a_inv  = 2'd3 - a;
   assign lsh    = {a_inv, 3'b000};
   assign rsh    = {a, 3'b000};

   always_comb begin
      we = WE_ALL;
      D  = mem_D;
      case (op)
         MIPS_LB:  D = {{24{byte_s[7]}}, byte_s};
         MIPS_LBU: D = {24'h0, byte_s};
         MIPS_LH:  D = {{16{half_s[15]}}, half_s};
         MIPS_LHU: D = {16'h0, half_s};
         MIPS_LW:  D = mem_D;
         // Unaligned pair: enables leave the bytes owned by the partner load intact.
         MIPS_LWL: begin
            D  = mem_D << lsh;
            we = WE_ALL << a_inv;
         end
         MIPS_LWR: begin
            D  = mem_D >> rsh;
            we = WE_ALL >> a;
         end
         default:  we = 4'b0000;
      endcase
   end

endmodule

// File: rtl/mips_wback.sv
// Register-file writer: arbitrates ALU results and one outstanding load onto
// the registered byte-enabled write port; load completion has priority.
module mips_wback
   import mips_wback_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_D,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [2:0]  ld_op,
   input  logic [1:0]  ld_a,
   input  logic [4:0]  ld_rd,
   input  logic        mem_ready,
   input  logic [31:0] mem_D,
   output logic        pend_valid,
   output logic [4:0]  pend_rd,
   output logic [4:0]  rd,
   output logic [3:0]  we,
   output logic [31:0] D
);

   logic        state;
   ld_req_t     pend;
   logic        done;
   logic        ld_acc;
   logic        alu_acc;
   logic [3:0]  fmt_we;
   logic [31:0] fmt_D;

   mips_load_align u_align (
      .op    (pend.op),
      .a     (pend.a),
      .mem_D (mem_D),
      .we    (fmt_we),
      .D     (fmt_D)
   );

   assign done       = (state == ST_WAIT) & mem_ready;
   assign ld_ready   = (state == ST_IDLE) | done;
   assign alu_ready  = !done;
   assign ld_acc     = ld_valid & ld_ready;
   assign alu_acc    = alu_valid & alu_ready;
   assign pend_valid = (state == ST_WAIT);
   assign pend_rd    = pend.rd;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
         pend  <= '0;
         rd    <= 5'd0;
         we    <= 4'b0000;
         D     <= 32'h0;
      end else begin
         // A completing load and a new request share the same edge: no bubble.
         if (ld_acc) begin
            state   <= ST_WAIT;
            pend.op <= ld_op;
            pend.a  <= ld_a;
            pend.rd <= ld_rd;
         end else if (done) begin
            state <= ST_IDLE;
            pend  <= '0;
         end

         if (done) begin
            rd <= pend.rd;
            we <= (pend.rd == 5'd0) ? 4'b0000 : fmt_we;
            D  <= fmt_D;
         end else if (alu_acc) begin
            rd <= alu_rd;
            we <= (alu_rd == 5'd0) ? 4'b0000 : WE_ALL;
            D  <= alu_D;
         end else begin
            we <= 4'b0000;
         end
      end
   end

endmodule

// File: tb/tb_mips_wback.sv
// Directed bench for mips_wback with a byte-lane behavioural model and a
// per-cycle compare process, plus literal spot checks.
module tb_mips_wback;

   logic        clock = 1'b0;
   logic        reset;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_D;
   logic        ld_valid;
   logic        ld_ready;
   logic [2:0]  ld_op;
   logic [1:0]  ld_a;
   logic [4:0]  ld_rd;
   logic        mem_ready;
   logic [31:0] mem_D;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic [4:0]  rd;
   logic [3:0]  we;
   logic [31:0] D;

   int checks = 0;
   int failures = 0;

   mips_wback dut (
      .clock(clock), .reset(reset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_D(alu_D),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_op(ld_op), .ld_a(ld_a), .ld_rd(ld_rd),
      .mem_ready(mem_ready), .mem_D(mem_D),
      .pend_valid(pend_valid), .pend_rd(pend_rd),
      .rd(rd), .we(we), .D(D)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: format a load from the byte-lane rules.
   function automatic void fmt(input logic [2:0] op, input logic [1:0] a, input logic [31:0] m,
                               output logic [3:0] w, output logic [31:0] d);
      logic [7:0] b [4];
      int ai, hi, j;
      for (int i = 0; i < 4; i++) b[i] = m[8*i +: 8];
      ai = int'(a);
      w = 4'b1111;
      d = 32'h0;
      case (op)
         3'd0: d = {{24{b[ai][7]}}, b[ai]};
         3'd4: d = {24'h0, b[ai]};
         3'd1, 3'd5: begin
            hi = a[1] ? 2 : 0;
            d = {(op == 3'd1 && b[hi+1][7]) ? 16'hFFFF : 16'h0000, b[hi+1], b[hi]};
         end
         3'd3: d = m;
         3'd2: begin
            w = 4'b0000;
            for (int i = 0; i < 4; i++) begin
               j = i + 3 - ai;
               if (j <= 3) begin d[8*j +: 8] = b[i]; w[j] = 1'b1; end
            end
         end
         3'd6: begin
            w = 4'b0000;
            for (int i = ai; i < 4; i++) begin d[8*(i-ai) +: 8] = b[i]; w[i-ai] = 1'b1; end
         end
         default: w = 4'b0000;
      endcase
   endfunction

   bit          armed = 0;
   bit          m_wait;
   logic [2:0]  m_op;
   logic [1:0]  m_a;
   logic [4:0]  m_rd;
   logic [4:0]  e_rd;
   logic [3:0]  e_we;
   logic [31:0] e_D;
   bit          e_dk;
   logic [31:0] rf [32];

   initial begin
      bit arm_now, done, ldacc;
      logic [3:0]  fw;
      logic [31:0] fd;
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      forever begin
         @(negedge clock); #2;
         if (armed) begin
            chk("ld_ready", {31'b0, ld_ready}, {31'b0, (!m_wait) || mem_ready});
            chk("alu_ready", {31'b0, alu_ready}, {31'b0, !(m_wait && mem_ready)});
         end
         arm_now = armed || reset;
         if (reset) begin
            m_wait = 0; m_rd = 0; e_rd = 0; e_we = 0; e_D = 0; e_dk = 1;
         end else if (armed) begin
            done  = m_wait && mem_ready;
            ldacc = ld_valid && (!m_wait || mem_ready);
            if (done) begin
               fmt(m_op, m_a, mem_D, fw, fd);
               e_rd = m_rd;
               e_we = (m_rd == 0) ? 4'b0 : fw;
               e_D  = fd;
               e_dk = (m_rd != 0) && (m_op != 3'd7);
            end else if (alu_valid) begin
               e_rd = alu_rd;
               e_we = (alu_rd == 0) ? 4'b0 : 4'hF;
               e_D  = alu_D;
               e_dk = (alu_rd != 0);
            end else begin
               e_we = 4'b0;
            end
            for (int k = 0; k < 4; k++)
               if (e_we[k]) rf[e_rd][8*k +: 8] = e_D[8*k +: 8];
            if (ldacc) begin
               m_wait = 1; m_op = ld_op; m_a = ld_a; m_rd = ld_rd;
            end else if (done) begin
               m_wait = 0; m_rd = 0;
            end
         end
         @(posedge clock); #1;
         armed = arm_now;
         if (armed) begin
            chk("rd", {27'b0, rd}, {27'b0, e_rd});
            chk("we", {28'b0, we}, {28'b0, e_we});
            if (e_dk) chk("D", D, e_D);
            chk("pend_valid", {31'b0, pend_valid}, {31'b0, m_wait});
            chk("pend_rd", {27'b0, pend_rd}, {27'b0, m_rd});
         end
      end
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   // Issue a load from IDLE and complete it on the next cycle.
   task automatic do_load(input logic [2:0] op, input logic [1:0] a, input logic [4:0] r,
                          input logic [31:0] m);
      ld_valid = 1; ld_op = op; ld_a = a; ld_rd = r;
      step();
      ld_valid = 0;
      mem_ready = 1; mem_D = m;
      step();
      mem_ready = 0;
   endtask

   initial begin
      reset = 1; alu_valid = 0; alu_rd = 0; alu_D = 0;
      ld_valid = 0; ld_op = 0; ld_a = 0; ld_rd = 0; mem_ready = 0; mem_D = 0;
      step(); step();
      chk("rst we", {28'b0, we}, 32'h0);
      chk("rst rd", {27'b0, rd}, 32'h0);
      chk("rst D", D, 32'h0);
      chk("rst pend_valid", {31'b0, pend_valid}, 32'h0);
      reset = 0;
      #1;
      chk("idle ld_ready", {31'b0, ld_ready}, 32'h1);
      chk("idle alu_ready", {31'b0, alu_ready}, 32'h1);

      alu_valid = 1; alu_rd = 5; alu_D = 32'hDEADBEEF;
      step();
      alu_valid = 0;
      chk("alu rd", {27'b0, rd}, 32'd5);
      chk("alu we", {28'b0, we}, 32'hF);
      chk("alu D", D, 32'hDEADBEEF);
      step();
      chk("alu we drop", {28'b0, we}, 32'h0);

      ld_valid = 1; ld_op = 3'd0; ld_a = 2'd1; ld_rd = 7;
      step();
      ld_valid = 0;
      chk("lb pend_valid", {31'b0, pend_valid}, 32'h1);
      chk("lb pend_rd", {27'b0, pend_rd}, 32'd7);
      mem_ready = 1; mem_D = 32'h8899AABB;
      step();
      mem_ready = 0;
      chk("lb D", D, 32'hFFFFFFAA);
      chk("lb we", {28'b0, we}, 32'hF);
      chk("lb pend clr", {31'b0, pend_valid}, 32'h0);

      do_load(3'd4, 2'd3, 5'd8, 32'h8899AABB);
      chk("lbu D", D, 32'h00000088);
      do_load(3'd1, 2'd2, 5'd8, 32'h8899AABB);
      chk("lh D", D, 32'hFFFF8899);

      do_load(3'd2, 2'd1, 5'd9, 32'h44332211);
      chk("lwl we", {28'b0, we}, 32'hC);
      chk("lwl D", D, 32'h22110000);
      do_load(3'd6, 2'd1, 5'd9, 32'h44332211);
      chk("lwr we", {28'b0, we}, 32'h7);
      chk("lwr D", D, 32'h00443322);
      chk("model merge r9", rf[9], 32'h22443322);

      // Collision: completion, new load and ALU result in the same cycle.
      ld_valid = 1; ld_op = 3'd3; ld_a = 0; ld_rd = 10;
      step();
      mem_ready = 1; mem_D = 32'hCAFEF00D;
      alu_valid = 1; alu_rd = 11; alu_D = 32'h12345678;
      ld_valid = 1; ld_op = 3'd3; ld_a = 0; ld_rd = 12;
      #1;
      chk("col alu_ready", {31'b0, alu_ready}, 32'h0);
      chk("col ld_ready", {31'b0, ld_ready}, 32'h1);
      step();
      mem_ready = 0; ld_valid = 0;
      chk("col ld rd", {27'b0, rd}, 32'd10);
      chk("col ld D", D, 32'hCAFEF00D);
      chk("col pend_valid", {31'b0, pend_valid}, 32'h1);
      chk("col pend_rd", {27'b0, pend_rd}, 32'd12);
      step();
      alu_valid = 0;
      chk("col alu rd", {27'b0, rd}, 32'd11);
      chk("col alu D", D, 32'h12345678);
      mem_ready = 1; mem_D = 32'h0BADBEEF;
      step();
      mem_ready = 0;
      chk("col ld2 D", D, 32'h0BADBEEF);

      do_load(3'd3, 2'd0, 5'd0, 32'h55AA55AA);
      chk("ld r0 we", {28'b0, we}, 32'h0);
      alu_valid = 1; alu_rd = 0; alu_D = 32'h1;
      step();
      alu_valid = 0;
      chk("alu r0 we", {28'b0, we}, 32'h0);

      ld_valid = 1; ld_op = 3'd3; ld_a = 0; ld_rd = 13;
      step();
      ld_valid = 0; reset = 1; mem_ready = 1; mem_D = 32'h77777777;
      step();
      reset = 0; mem_ready = 0;
      chk("rst wait we", {28'b0, we}, 32'h0);
      chk("rst wait pend", {31'b0, pend_valid}, 32'h0);

      mem_ready = 1; mem_D = 32'h12121212;
      step();
      mem_ready = 0;
      chk("idle mem we", {28'b0, we}, 32'h0);

      do_load(3'd7, 2'd0, 5'd14, 32'h33333333);
      chk("op7 we", {28'b0, we}, 32'h0);
      chk("op7 pend", {31'b0, pend_valid}, 32'h0);

      for (int op = 0; op < 8; op++)
         for (int a = 0; a < 4; a++)
            do_load(3'(op), 2'(a), 5'(op*4 + a + 1), (a[0]) ? 32'h8899AABB : 32'hF4731265);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
